load_use_scoreboard: RTL and testbench

LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

---
 rtl/load_use_scoreboard_if.sv | 32 +++
 rtl/load_use_scoreboard.sv | 104 ++++++++++
 tb/tb_load_use_scoreboard.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_use_scoreboard_if.sv
// Bundle of pipeline-control signals between the hazard scoreboard and
// the surrounding pipeline: EX/decode operand info in, stall controls out.
interface load_use_scoreboard_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) ();
  logic                     exValid;
  logic                     exMemRead;
  logic [REG_W-1:0]         exRd;
  logic [NUM_SRC*REG_W-1:0] decSrc;
  logic [NUM_SRC-1:0]       decSrcUsed;
  logic                     memBusy;
  logic                     flush;
  logic                     clrCount;
  logic                     stall;
  logic                     bubble;
  logic [NUM_SRC-1:0]       hazardSrcMask;
  logic [CNT_W-1:0]         stallCount;

  // Pipeline side: drives stage info, receives stall controls.
  modport master (
    output exValid, exMemRead, exRd, decSrc, decSrcUsed, memBusy, flush, clrCount,
    input  stall, bubble, hazardSrcMask, stallCount
  );

  // Scoreboard side.
  modport slave (
    input  exValid, exMemRead, exRd, decSrc, decSrcUsed, memBusy, flush, clrCount,
    output stall, bubble, hazardSrcMask, stallCount
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard. Tracks loads from EX for LOAD_LAT cycles
// (EX plus LOAD_LAT-1 shift entries) and stalls any decode operand that
// reads a destination whose data is not yet forwardable.
module load_use_scoreboard #(
  parameter int REG_W    = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  load_use_scoreboard_if.slave bus
);

  // Number of tracked entries behind EX; storage keeps at least one slot
  // so the arrays stay legal, but that slot never goes valid when unused.
  localparam int              PEND_N  = LOAD_LAT - 1;
  localparam int              PEND_SZ = (PEND_N > 0) ? PEND_N : 1;
  localparam bit              PEND_EN = (PEND_N > 0);
  localparam logic [REG_W-1:0] ZERO_RD = REG_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry 0 is the youngest tracked load (one cycle past EX).
  logic [PEND_SZ-1:0] pend_valid_q, pend_valid_d;
  logic [REG_W-1:0]   pend_rd_q [PEND_SZ];
  logic [REG_W-1:0]   pend_rd_d [PEND_SZ];
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic [NUM_SRC-1:0] hazard_mask;
  logic               hazard;
  logic               bubble_int;
  logic               ex_load;

  assign ex_load = bus.exValid & bus.exMemRead;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_W-1:0] src;
    logic             pend_hit;

    assign src = bus.decSrc[gi*REG_W +: REG_W];

    // Does any tracked load still owe this operand its data?
    always_comb begin
      pend_hit = 1'b0;
      for (int k = 0; k < PEND_SZ; k++) begin
        if (pend_valid_q[k] && (pend_rd_q[k] == src)) begin
          pend_hit = 1'b1;
        end
      end
    end

    // Reset gating keeps outputs quiet while reset_n is held low even if
    // the EX-stage inputs look like a load.
    assign hazard_mask[gi] = reset_n & ~bus.flush & bus.decSrcUsed[gi] &
                             (src != ZERO_RD) &
                             ((ex_load & (bus.exRd == src)) | pend_hit);
  end

  assign hazard     = |hazard_mask;
  assign bubble_int = hazard & ~bus.memBusy;

  assign bus.hazardSrcMask = hazard_mask;
  assign bus.stall         = reset_n & (hazard | bus.memBusy);
  assign bus.bubble        = bubble_int;
  assign bus.stallCount    = stall_count_q;

  // Advance the load shift chain and the stall counter; a frozen
  // pipeline (memBusy) holds everything, including a pending clear.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_rd_d     = pend_rd_q;
    stall_count_d = stall_count_q;
    if (!bus.memBusy) begin
      pend_valid_d[0] = PEND_EN & ex_load & ~bus.flush & (bus.exRd != ZERO_RD);
      pend_rd_d[0]    = bus.exRd;
      for (int k = 1; k < PEND_SZ; k++) begin
        pend_valid_d[k] = pend_valid_q[k-1];
        pend_rd_d[k]    = pend_rd_q[k-1];
      end
      if (bus.clrCount) begin
        stall_count_d = '0;
      end else if (bubble_int && (stall_count_q != CNT_MAX)) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards every tracked load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= '0;
      for (int k = 0; k < PEND_SZ; k++) begin
        pend_rd_q[k] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_rd_q     <= pend_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: three instances at LOAD_LAT 1, 2
// and 3 exercised one at a time with hand-computed expected values.
module tb_load_use_scoreboard;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  load_use_scoreboard_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(16)) b1 ();
  load_use_scoreboard_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(3))  b2 ();
  load_use_scoreboard_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(16)) b3 ();

  load_use_scoreboard #(.REG_W(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG(31), .CNT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave));
  load_use_scoreboard #(.REG_W(5), .NUM_SRC(2), .LOAD_LAT(2), .ZERO_REG(31), .CNT_W(3)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave));
  load_use_scoreboard #(.REG_W(5), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG(31), .CNT_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .bus(b3.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    b1.exValid = 0; b1.exMemRead = 0; b1.exRd = 0; b1.decSrc = 0; b1.decSrcUsed = 0;
    b1.memBusy = 0; b1.flush = 0; b1.clrCount = 0;
    b2.exValid = 0; b2.exMemRead = 0; b2.exRd = 0; b2.decSrc = 0; b2.decSrcUsed = 0;
    b2.memBusy = 0; b2.flush = 0; b2.clrCount = 0;
    b3.exValid = 0; b3.exMemRead = 0; b3.exRd = 0; b3.decSrc = 0; b3.decSrcUsed = 0;
    b3.memBusy = 0; b3.flush = 0; b3.clrCount = 0;
  endtask

  initial begin
    idle_all();
    // Hazard-looking inputs while reset is held: outputs must stay low.
    b1.exValid = 1; b1.exMemRead = 1; b1.exRd = 5; b1.decSrc = {5'd0, 5'd5}; b1.decSrcUsed = 2'b01;
    settle();
    check("rst_stall", 32'(b1.stall), 0);
    check("rst_bubble", 32'(b1.bubble), 0);
    check("rst_mask", 32'(b1.hazardSrcMask), 0);
    check("rst_count", 32'(b1.stallCount), 0);
    tick();
    tick();
    reset_n = 1'b1;

    // LAT1: single-cycle load-use on operand 0.
    settle();
    check("l1_stall", 32'(b1.stall), 1);
    check("l1_bubble", 32'(b1.bubble), 1);
    check("l1_mask", 32'(b1.hazardSrcMask), 32'h1);
    tick();
    b1.exValid = 0;
    settle();
    check("l1_next_stall", 32'(b1.stall), 0);
    check("l1_count", 32'(b1.stallCount), 1);
    // Operand 1 hazard plus clear in the same cycle as the bubble.
    b1.exValid = 1; b1.exMemRead = 1; b1.exRd = 3; b1.decSrc = {5'd3, 5'd8}; b1.decSrcUsed = 2'b11;
    b1.clrCount = 1;
    settle();
    check("l1_mask_src1", 32'(b1.hazardSrcMask), 32'h2);
    tick();
    idle_all();
    settle();
    check("l1_clr_with_bubble", 32'(b1.stallCount), 0);
    // Non-load producer never stalls.
    b1.exValid = 1; b1.exMemRead = 0; b1.exRd = 5; b1.decSrc = {5'd0, 5'd5}; b1.decSrcUsed = 2'b01;
    settle();
    check("l1_nonload", 32'(b1.stall), 0);
    tick();
    idle_all();

    // LAT3: dependent operand 1 sees exactly three stall cycles.
    b3.exValid = 1; b3.exMemRead = 1; b3.exRd = 7; b3.decSrc = {5'd7, 5'd0}; b3.decSrcUsed = 2'b10;
    settle();
    check("l3_c0_stall", 32'(b3.stall), 1);
    check("l3_c0_mask", 32'(b3.hazardSrcMask), 32'h2);
    tick();
    b3.exValid = 0;
    settle();
    check("l3_c1_stall", 32'(b3.stall), 1);
    tick();
    settle();
    check("l3_c2_stall", 32'(b3.stall), 1);
    tick();
    settle();
    check("l3_c3_stall", 32'(b3.stall), 0);
    check("l3_count", 32'(b3.stallCount), 3);
    // Two back-to-back loads to r6: hazard lasts until the younger retires.
    b3.exValid = 1; b3.exMemRead = 1; b3.exRd = 6; b3.decSrcUsed = 2'b00;
    settle();
    check("l3_dup_c0", 32'(b3.stall), 0);
    tick();
    b3.decSrc = {5'd0, 5'd6}; b3.decSrcUsed = 2'b01;
    settle();
    check("l3_dup_c1", 32'(b3.stall), 1);
    tick();
    b3.exValid = 0;
    settle();
    check("l3_dup_c2", 32'(b3.stall), 1);
    tick();
    settle();
    check("l3_dup_c3", 32'(b3.stall), 1);
    tick();
    settle();
    check("l3_dup_c4", 32'(b3.stall), 0);
    check("l3_dup_count", 32'(b3.stallCount), 6);
    // Flush masks the hazard but does not squash an older tracked load.
    b3.exValid = 1; b3.exMemRead = 1; b3.exRd = 12; b3.decSrcUsed = 2'b00;
    tick();
    b3.exValid = 0; b3.flush = 1; b3.decSrc = {5'd0, 5'd12}; b3.decSrcUsed = 2'b01;
    settle();
    check("l3_flush_stall", 32'(b3.stall), 0);
    check("l3_flush_bubble", 32'(b3.bubble), 0);
    tick();
    b3.flush = 0;
    settle();
    check("l3_older_kept", 32'(b3.stall), 1);
    tick();
    idle_all();

    // LAT2: zero register and unused operands never hazard.
    b2.exValid = 1; b2.exMemRead = 1; b2.exRd = 31; b2.decSrc = {5'd0, 5'd31}; b2.decSrcUsed = 2'b01;
    settle();
    check("l2_zero_reg", 32'(b2.stall), 0);
    tick();
    b2.exValid = 0;
    settle();
    check("l2_zero_reg_next", 32'(b2.stall), 0);
    b2.exValid = 1; b2.exRd = 4; b2.decSrc = {5'd0, 5'd4}; b2.decSrcUsed = 2'b00;
    settle();
    check("l2_unused", 32'(b2.stall), 0);
    tick();
    b2.exValid = 0;
    settle();
    check("l2_unused_next", 32'(b2.stall), 0);
    tick();
    // memBusy freeze in the middle of a hazard.
    b2.exValid = 1; b2.exMemRead = 1; b2.exRd = 10; b2.decSrc = {5'd0, 5'd10}; b2.decSrcUsed = 2'b01;
    settle();
    check("l2_mb_c0_bubble", 32'(b2.bubble), 1);
    tick();
    b2.exValid = 0; b2.memBusy = 1;
    for (int n = 0; n < 4; n++) begin
      settle();
      check($sformatf("l2_mb_stall%0d", n), 32'(b2.stall), 1);
      check($sformatf("l2_mb_bubble%0d", n), 32'(b2.bubble), 0);
      check($sformatf("l2_mb_count%0d", n), 32'(b2.stallCount), 1);
      tick();
    end
    b2.memBusy = 0;
    settle();
    check("l2_mb_resume_bubble", 32'(b2.bubble), 1);
    tick();
    settle();
    check("l2_mb_done_stall", 32'(b2.stall), 0);
    check("l2_mb_done_count", 32'(b2.stallCount), 2);
    // Flush with an EX load: no stall now, and nothing tracked afterwards.
    b2.exValid = 1; b2.exMemRead = 1; b2.exRd = 9; b2.decSrc = {5'd0, 5'd9}; b2.decSrcUsed = 2'b01;
    b2.flush = 1;
    settle();
    check("l2_flush_stall", 32'(b2.stall), 0);
    tick();
    b2.exValid = 0; b2.flush = 0;
    settle();
    check("l2_flush_pend_empty", 32'(b2.stall), 0);
    // Saturation of a 3-bit counter (max 7) starting from 2.
    b2.exValid = 1; b2.exMemRead = 1; b2.exRd = 1; b2.decSrc = {5'd0, 5'd1}; b2.decSrcUsed = 2'b01;
    for (int n = 1; n <= 6; n++) begin
      tick();
      settle();
      check($sformatf("l2_sat%0d", n), 32'(b2.stallCount), (2 + n > 7) ? 7 : 2 + n);
    end
    tick();
    idle_all();
    tick();

    // Reset in the middle of a LAT3 stall.
    b3.exValid = 1; b3.exMemRead = 1; b3.exRd = 7; b3.decSrc = {5'd0, 5'd7}; b3.decSrcUsed = 2'b01;
    tick();
    b3.exValid = 0;
    settle();
    check("l3_pre_rst_stall", 32'(b3.stall), 1);
    reset_n = 1'b0;
    settle();
    check("l3_rst_stall", 32'(b3.stall), 0);
    check("l3_rst_bubble", 32'(b3.bubble), 0);
    check("l3_rst_mask", 32'(b3.hazardSrcMask), 0);
    check("l3_rst_count", 32'(b3.stallCount), 0);
    tick();
    reset_n = 1'b1;
    settle();
    check("l3_post_rst_pend", 32'(b3.stall), 0);
    b3.exValid = 1;
    settle();
    check("l3_post_rst_ex", 32'(b3.stall), 1);
    tick();
    idle_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
